// File: rtl/text_cursor_writer.sv
// ----------------------------------------------------------------------------
// text_cursor_writer
//   Turns a stream of ASCII bytes into single-cycle writes to the character
//   RAM read by the LCD text renderer, and keeps a cursor over the
//   COLS x ROWS character grid. Handles CR, LF, BS and FF, line wrap,
//   page wrap and a full-screen hardware clear.
//
// Ports
//   MemoryClk   in   clock, everything on the rising edge
//   Reset       in   synchronous active-high reset (starts a full clear)
//   char_valid  in   char_data holds a byte this cycle
//   char_data   in   incoming ASCII byte
//   char_ready  out  a byte can be accepted this cycle (IDLE only)
//   wr_en       out  character RAM write strobe
//   wr_addr     out  character RAM address, row*COLS+col
//   wr_data     out  byte written
//   cursor_row  out  cursor row, 0..ROWS-1
//   cursor_col  out  cursor column, 0..COLS-1
//   busy        out  a clear sequence is running
//
// Build option
//   TEXT_LINE_CLEAR_EN : every move onto a new row first fills that row with
//                        FILL_CHAR (CLEAR_LINE state). Undefined: old row
//                        contents are left in place.
// ----------------------------------------------------------------------------
module text_cursor_writer #(
  parameter int          COLS      = 79,
  parameter int          ROWS      = 30,
  parameter int          ADDR_W    = 12,
  parameter logic [7:0]  FILL_CHAR = 8'h20
) (
  input  logic              MemoryClk,
  input  logic              Reset,
  input  logic              char_valid,
  input  logic [7:0]        char_data,
  output logic              char_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [4:0]        cursor_row,
  output logic [6:0]        cursor_col,
  output logic              busy
);

  localparam logic [1:0] S_CLEAR_ALL  = 2'd0;
  localparam logic [1:0] S_IDLE       = 2'd1;
`ifdef TEXT_LINE_CLEAR_EN
  localparam logic [1:0] S_CLEAR_LINE = 2'd2;
  localparam logic [ADDR_W-1:0] LAST_COL_A = ADDR_W'(COLS - 1);
`endif

  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);
  localparam logic [6:0]        LAST_COL  = 7'(COLS - 1);
  localparam logic [4:0]        LAST_ROW  = 5'(ROWS - 1);

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic [4:0]        r_row;
  logic [6:0]        r_col;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;

  logic [ADDR_W-1:0] w_line_base;
  logic [ADDR_W-1:0] w_cur_addr;
  logic [4:0]        w_row_next;
  logic              w_accept;
  logic              w_printable;

  assign w_line_base = ADDR_W'(r_row) * ADDR_W'(COLS);
  assign w_cur_addr  = w_line_base + ADDR_W'(r_col);
  // Row increment past the last row wraps to the top: no scrolling.
  assign w_row_next  = (r_row == LAST_ROW) ? 5'd0 : r_row + 5'd1;
  assign w_accept    = char_valid && (r_state == S_IDLE);
  assign w_printable = (char_data >= 8'h20) && (char_data <= 8'h7E);

  // Cursor, clear sequencing and registered RAM write port.
  always_ff @(posedge MemoryClk) begin
    if (Reset) begin
      r_state   <= S_CLEAR_ALL;
      r_cnt     <= '0;
      r_row     <= 5'd0;
      r_col     <= 7'd0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= 8'h00;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        S_CLEAR_ALL: begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= r_cnt;
          r_wr_data <= FILL_CHAR;
          if (r_cnt == LAST_CELL) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_row   <= 5'd0;
            r_col   <= 7'd0;
          end else begin
            r_cnt <= r_cnt + ADDR_W'(1);
          end
        end

        S_IDLE: begin
          if (w_accept) begin
            if (w_printable) begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= w_cur_addr;
              r_wr_data <= char_data;
              if (r_col == LAST_COL) begin
                r_col <= 7'd0;
                r_row <= w_row_next;
`ifdef TEXT_LINE_CLEAR_EN
                r_state <= S_CLEAR_LINE;
                r_cnt   <= '0;
`endif
              end else begin
                r_col <= r_col + 7'd1;
              end
            end else if (char_data == 8'h0D) begin
              r_col <= 7'd0;
            end else if (char_data == 8'h0A) begin
              r_col <= 7'd0;
              r_row <= w_row_next;
`ifdef TEXT_LINE_CLEAR_EN
              r_state <= S_CLEAR_LINE;
              r_cnt   <= '0;
`endif
            end else if (char_data == 8'h08) begin
              // Backspace stops at column 0; it never climbs to the row above.
              if (r_col != 7'd0) begin
                r_col     <= r_col - 7'd1;
                r_wr_en   <= 1'b1;
                r_wr_addr <= w_cur_addr - ADDR_W'(1);
                r_wr_data <= FILL_CHAR;
              end else begin
                r_col <= r_col;
              end
            end else if (char_data == 8'h0C) begin
              r_state <= S_CLEAR_ALL;
              r_cnt   <= '0;
            end else begin
              r_col <= r_col;
            end
          end else begin
            r_col <= r_col;
          end
        end

`ifdef TEXT_LINE_CLEAR_EN
        S_CLEAR_LINE: begin
          // r_row already points at the new row; r_col stays 0.
          r_wr_en   <= 1'b1;
          r_wr_addr <= w_line_base + r_cnt;
          r_wr_data <= FILL_CHAR;
          if (r_cnt == LAST_COL_A) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + ADDR_W'(1);
          end
        end
`endif

        default: begin
          r_state <= S_CLEAR_ALL;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign char_ready = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign cursor_row = r_row;
  assign cursor_col = r_col;

endmodule

// File: tb/tb_text_cursor_writer.sv
// ----------------------------------------------------------------------------
// tb_text_cursor_writer
//   Scoreboard bench for text_cursor_writer. The driver feeds bytes, updates a
//   grid-level cursor model and queues the RAM writes (with their cycle) that
//   each byte must cause; a monitor pops and compares on every wr_en.
// ----------------------------------------------------------------------------
module tb_text_cursor_writer;

  localparam int COLS  = 79;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;

  logic        MemoryClk = 1'b0;
  logic        Reset     = 1'b1;
  logic        char_valid = 1'b0;
  logic [7:0]  char_data  = 8'h00;
  logic        char_ready;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic [4:0]  cursor_row;
  logic [6:0]  cursor_col;
  logic        busy;

  text_cursor_writer dut (
    .MemoryClk (MemoryClk),
    .Reset     (Reset),
    .char_valid(char_valid),
    .char_data (char_data),
    .char_ready(char_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .cursor_row(cursor_row),
    .cursor_col(cursor_col),
    .busy      (busy)
  );

  always #5 MemoryClk = ~MemoryClk;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  wr_t q[$];
  wr_t mon_e;
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  int  m_row = 0;
  int  m_col = 0;
  int  exp_ready = 0;

  always @(posedge MemoryClk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int a, input int d, input int c);
    q.push_back('{addr: a, data: d, cyc: c});
  endtask

  // Monitor: every write the DUT presents must be the next one expected.
  always @(negedge MemoryClk) begin
    if (Reset === 1'b0) begin
      if (wr_en === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0d data %0h at cycle %0d, expected none",
                   wr_addr, wr_data, cyc);
        end else begin
          mon_e = q.pop_front();
          chk("wr_addr", 32'(wr_addr), mon_e.addr);
          chk("wr_data", 32'(wr_data), mon_e.data);
          chk("wr_cycle", cyc, mon_e.cyc);
        end
      end else if (q.size() > 0 && q[0].cyc <= cyc) begin
        mon_e = q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_write: got no write at cycle %0d, expected addr %0d data %0h",
                 cyc, mon_e.addr, mon_e.data);
      end
    end
  end

  // Reference model: grid rules applied to one accepted byte (k0 = cycle before acceptance).
  task automatic apply_byte(input logic [7:0] b, input int k0, output bit is_ff);
    is_ff = 1'b0;
    exp_ready = k0 + 1;
    if (b >= 8'h20 && b <= 8'h7E) begin
      push(m_row * COLS + m_col, int'(b), k0 + 1);
      if (m_col == COLS - 1) begin
        m_col = 0;
        m_row = (m_row + 1) % ROWS;
`ifdef TEXT_LINE_CLEAR_EN
        for (int i = 0; i < COLS; i++) push(m_row * COLS + i, 32'h20, k0 + 2 + i);
        exp_ready = k0 + 1 + COLS;
`endif
      end else begin
        m_col = m_col + 1;
      end
    end else if (b == 8'h0D) begin
      m_col = 0;
    end else if (b == 8'h0A) begin
      m_col = 0;
      m_row = (m_row + 1) % ROWS;
`ifdef TEXT_LINE_CLEAR_EN
      for (int i = 0; i < COLS; i++) push(m_row * COLS + i, 32'h20, k0 + 2 + i);
      exp_ready = k0 + 1 + COLS;
`endif
    end else if (b == 8'h08) begin
      if (m_col > 0) begin
        m_col = m_col - 1;
        push(m_row * COLS + m_col, 32'h20, k0 + 1);
      end
    end else if (b == 8'h0C) begin
      for (int i = 0; i < CELLS; i++) push(i, 32'h20, k0 + 2 + i);
      exp_ready = k0 + 1 + CELLS;
      m_row = 0;
      m_col = 0;
      is_ff = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge MemoryClk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (char_ready !== 1'b1 && n < 6000) begin
      step();
      n++;
    end
    if (char_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: char_ready %b after %0d cycles, expected 1", char_ready, n);
    end else begin
      chk("ready_cycle", cyc, exp_ready);
      chk("busy_idle", 32'(busy), 0);
      chk("cursor_row", 32'(cursor_row), m_row);
      chk("cursor_col", 32'(cursor_col), m_col);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int k0;
    bit is_ff;
    wait_ready();
    repeat (gap) step();
    char_data  = b;
    char_valid = 1'b1;
    chk("ready_at_send", 32'(char_ready), 1);
    k0 = cyc;
    apply_byte(b, k0, is_ff);
    step();
    char_valid = 1'b0;
    chk("busy_after_byte", 32'(busy), 32'(exp_ready > cyc));
    if (!is_ff) begin
      chk("cursor_row", 32'(cursor_row), m_row);
      chk("cursor_col", 32'(cursor_col), m_col);
    end
  endtask

  task automatic do_reset();
    Reset      = 1'b1;
    char_valid = 1'b0;
    q.delete();
    step();
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    chk("rst_cursor_row", 32'(cursor_row), 0);
    chk("rst_cursor_col", 32'(cursor_col), 0);
    chk("rst_char_ready", 32'(char_ready), 0);
    chk("rst_busy", 32'(busy), 1);
    Reset = 1'b0;
    for (int i = 0; i < CELLS; i++) push(i, 32'h20, cyc + 1 + i);
    exp_ready = cyc + CELLS;
    m_row = 0;
    m_col = 0;
  endtask

  initial begin
    logic [7:0] b;
    int r;
    step();
    // Power-up clear.
    do_reset();
    wait_ready();

    // Back-to-back printable bytes.
    send(8'h41, 0);
    send(8'h42, 0);

    // Line wrap: 78 'x' from column 0, then 'y' at col 78 and 'z' on row 1.
    send(8'h0D, 0);
    for (int i = 0; i < 78; i++) send(8'h78, 0);
    send(8'h79, 0);
    send(8'h7A, 0);

    // Backspace at (0,3) and at column 0.
    send(8'h0C, 0);
    send(8'h61, 0);
    send(8'h62, 0);
    send(8'h63, 0);
    send(8'h08, 0);
    for (int i = 0; i < 5; i++) send(8'h0A, 0);
    send(8'h08, 0);

    // LF from the last row wraps to the top; CR and BEL do nothing.
    for (int i = 0; i < 24; i++) send(8'h0A, 0);
    for (int i = 0; i < 10; i++) send(8'h6B, 0);
    send(8'h0A, 0);
    send(8'h0D, 0);
    send(8'h07, 0);

    // Writing the very last cell sends the cursor home.
    send(8'h0C, 0);
    for (int i = 0; i < ROWS - 1; i++) send(8'h0A, 0);
    for (int i = 0; i < COLS; i++) send(8'h2E, 0);

    // Reset in the middle of a form-feed clear restarts the clear from 0.
    send(8'h0C, 0);
    repeat (1000) step();
    do_reset();
    wait_ready();

    // Randomized traffic with idle gaps.
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 70)      b = 8'($urandom_range(32, 126));
      else if (r < 78) b = 8'h0D;
      else if (r < 86) b = 8'h0A;
      else if (r < 94) b = 8'h08;
      else if (r < 97) b = 8'($urandom_range(127, 255));
      else if (r < 99) b = 8'h01;
      else             b = 8'h0C;
      send(b, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
    end

    wait_ready();
    repeat (5) step();
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/text_cursor_writer.md
Name: text_cursor_writer

Overview:
- Upstream feeder for the LCD text renderer.
- Accepts a stream of ASCII bytes (e.g. from a UART receiver) and maintains a cursor over the 79x30 character grid.
- Issues single-cycle writes into the dual-port character RAM that the renderer reads at address row*SignsPerRow+column.
- Handles CR, LF, BS and FF control codes, line wrap, page wrap, and hardware screen clear.

Parameters:
- COLS, 79, characters per row; must equal the renderer's SignsPerRow.
- ROWS, 30, text rows per screen.
- ADDR_W, 12, character RAM address width; must satisfy COLS*ROWS <= 2^ADDR_W.
- FILL_CHAR, 8'h20, code written by every clear operation (space).

Ports:
- MemoryClk  in  1  single clock; all logic is on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- char_valid  in  1  char_data is valid this cycle.
- char_data  in  8  incoming ASCII byte.
- char_ready  out  1  block can accept a byte this cycle.
- wr_en  out  1  character RAM write strobe, one cycle per cell.
- wr_addr  out  ADDR_W  character RAM address = row*COLS+col.
- wr_data  out  8  byte written.
- cursor_row  out  5  current cursor row, 0..ROWS-1.
- cursor_col  out  7  current cursor column, 0..COLS-1.
- busy  out  1  a clear sequence is in progress.

Behaviour:
- Reset values while Reset=1: wr_en=0, wr_addr=0, wr_data=0, cursor_row=0, cursor_col=0, char_ready=0, busy=1. State is forced to CLEAR_ALL with clear counter 0.
- Reset asserted mid-sequence aborts that sequence and restarts CLEAR_ALL from address 0.
- Handshake: a byte is accepted on a cycle with char_valid && char_ready. char_ready=1 only in IDLE; throughput is 1 byte/cycle.
- Latency: a byte accepted in cycle N produces its write (if any) in cycle N+1. The address uses the cursor value from cycle N. The cursor update is visible in cycle N+1.
- States:
  - CLEAR_ALL: wr_en=1, wr_data=FILL_CHAR, wr_addr counts 0..COLS*ROWS-1, one cell per cycle (2370 cycles by default). Then cursor=(0,0), state->IDLE, busy=0. char_ready=0 throughout.
  - IDLE: decodes accepted bytes:
    - 0x20..0x7E: write the byte at the cursor, then advance col. If col==COLS-1, wrap: col=0, row+1.
    - 0x0D (CR): col=0, no write.
    - 0x0A (LF): col=0, row+1, no write.
    - 0x08 (BS): if col>0, col-1 and write FILL_CHAR at the new position; if col==0, no action (no wrap back to the previous row).
    - 0x0C (FF): state->CLEAR_ALL, busy=1.
    - All other codes: accepted and discarded, no write, no cursor change.
  - CLEAR_LINE: exists only with TEXT_LINE_CLEAR_EN (see Optional Feature).
- Row increment from ROWS-1 wraps to row 0 (page wrap). There is no scrolling.
- When the last cell (ROWS-1, COLS-1) is written, the cursor goes to (0,0).
- wr_addr is always < COLS*ROWS. No write ever targets an out-of-range address.
- Only one write per cycle. A clear never overlaps a character write.

Optional Feature:
- Macro: TEXT_LINE_CLEAR_EN.
- Defined: any cursor move to a new row (wrap, LF, page wrap) enters CLEAR_LINE.
  - CLEAR_LINE writes FILL_CHAR to row*COLS .. row*COLS+COLS-1, one cell per cycle (COLS cycles).
  - char_ready=0 and busy=1 during CLEAR_LINE.
  - Returns to IDLE with the cursor at (row, 0).
  - The first CLEAR_LINE write appears in the cycle after the write or control cycle that moved the row.
- Not defined: the new row's old contents remain; no CLEAR_LINE state exists.

Test Plan:
- Release Reset -> busy=1, exactly 2370 writes of 0x20 to addresses 0..2369, then busy=0, char_ready=1, cursor=(0,0).
- Send 'A','B' back-to-back after clear -> writes (0,0x41), (1,0x42) on consecutive cycles, each one cycle after acceptance; cursor=(0,2).
- Send 78 'x' then 'y','z' -> 'y' written at addr 78; 'z' written at addr 79; cursor=(1,1). With TEXT_LINE_CLEAR_EN: 79 fill writes to addresses 79..157 occur between 'y' and 'z', and char_ready=0 during them.
- Cursor (0,3), send 0x08 -> write 0x20 to addr 2, cursor=(0,2). Cursor (5,0), send 0x08 -> no write, cursor unchanged.
- Cursor (29,10), send 0x0A -> cursor=(0,0), no write. Then send 0x0D, 0x07 -> no writes, cursor stays (0,0).
- Mid-FF clear (counter ~1000), assert Reset for 1 cycle -> clear restarts at addr 0 and completes all 2370 writes; no char_ready pulse during it.
